// File: rtl/uart_receiver.sv
// UART receiver: idle-high line, start bit, DATA_WIDTH data bits MSB first, one stop bit.
// Received words are offered on a valid/ready port; framing errors and overruns are pulsed.
module uart_receiver #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 2);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] BIT_WAIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_WAIT = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic [2:0]            state_reg, state_next;
  logic [CNT_W-1:0]      wait_reg, wait_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] word_reg, word_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  frame_err_reg;
  logic                  overrun_reg;
  logic                  sample;
  logic                  done;
  logic                  bad_stop;

  // wait_reg counts down the cycles left until the next mid-bit sample.
  assign sample = (wait_reg == '0);

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    bit_next   = bit_reg;
    word_next  = word_reg;
    done       = 1'b0;
    bad_stop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx) begin
          bit_next = '0;
          // With HALF==0 the start bit's own sample is this very cycle.
          if (HALF == 0) begin
            state_next = DATA;
            wait_next  = BIT_WAIT;
          end else begin
            state_next = START;
            wait_next  = HALF_WAIT;
          end
        end
      end
      START: begin
        if (sample) begin
          if (rx) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            wait_next  = BIT_WAIT;
          end
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end
      DATA: begin
        if (sample) begin
          word_next = {word_reg[DATA_WIDTH-2:0], rx};
          wait_next = BIT_WAIT;
          if (bit_reg == LAST_BIT) begin
            state_next = STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end
      STOP: begin
        if (sample) begin
          if (rx) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            bad_stop   = 1'b1;
            state_next = BRK;
          end
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end
      BRK: begin
        // A held-low line must return high before a new start is recognised.
        if (rx) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      bit_reg   <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      bit_reg   <= bit_next;
      word_reg  <= word_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= bad_stop;
      overrun_reg   <= done && valid_reg && !ready;
      // A pending unconsumed word wins over a newly completed one.
      if (done && (!valid_reg || ready)) begin
        data_reg  <= word_reg;
        valid_reg <= 1'b1;
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one instance at 1 clk/bit, one at 4 clks/bit.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       rx1 = 1'b1, rx4 = 1'b1;
  logic       ready1 = 1'b1, ready4 = 1'b0;
  logic [7:0] data1, data4;
  logic       valid1, valid4, frame_err1, frame_err4, overrun1, overrun4;

  int n_checks = 0;
  int n_fail   = 0;

  // Event counters, sampled at each posedge for the cycle just ending.
  int vhi1 = 0, fe1 = 0, ov1 = 0, vhi4 = 0, fe4 = 0;

  always #5 CLK = ~CLK;

  uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .rx(rx1), .data(data1), .valid(valid1),
    .ready(ready1), .frame_err(frame_err1), .overrun(overrun1)
  );

  uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .rx(rx4), .data(data4), .valid(valid4),
    .ready(ready4), .frame_err(frame_err4), .overrun(overrun4)
  );

  always @(posedge CLK) begin
    if (valid1)     vhi1 <= vhi1 + 1;
    if (frame_err1) fe1  <= fe1 + 1;
    if (overrun1)   ov1  <= ov1 + 1;
    if (valid4)     vhi4 <= vhi4 + 1;
    if (frame_err4) fe4  <= fe4 + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx4 = b;
    else     rx1 = b;
  endtask

  // Drives start, 8 data bits MSB first, then the stop bit, n cycles each.
  // Returns in the cycle right after the last stop-bit cycle.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int n);
    logic [9:0] bits;
    bits = {1'b0, b, stop};
    $display("frame: dut%0d byte=%02h stop=%0b clks/bit=%0d", sel ? 4 : 1, b, stop, n);
    for (int k = 9; k >= 0; k--) begin
      for (int j = 0; j < n; j++) begin
        drive(sel, bits[k]);
        tick();
      end
    end
  endtask

  task automatic idle(input int n);
    rx1 = 1'b1;
    rx4 = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  int base_v, base_fe, base_ov;

  initial begin
    // Reset state
    RESET = 1'b1;
    repeat (3) tick();
    check_val("rst_valid1", valid1, 0);
    check_val("rst_data1", data1, 0);
    check_val("rst_fe1", frame_err1, 0);
    check_val("rst_ov1", overrun1, 0);
    check_val("rst_valid4", valid4, 0);
    RESET = 1'b0;
    idle(2);

    // 1: single 0xA5 frame, valid for exactly one cycle
    base_v = vhi1;
    send_frame(1'b0, 8'hA5, 1'b1, 1);
    check_val("t1_valid", valid1, 1);
    check_val("t1_data", data1, 8'hA5);
    idle(1);
    check_val("t1_valid_drop", valid1, 0);
    check_val("t1_vcycles", vhi1 - base_v, 1);

    // 2: back-to-back frames, no idle gap
    idle(2);
    base_v = vhi1;
    send_frame(1'b0, 8'h3C, 1'b1, 1);
    check_val("t2_valid_a", valid1, 1);
    check_val("t2_data_a", data1, 8'h3C);
    send_frame(1'b0, 8'hC3, 1'b1, 1);
    check_val("t2_valid_b", valid1, 1);
    check_val("t2_data_b", data1, 8'hC3);
    idle(1);
    check_val("t2_vcycles", vhi1 - base_v, 2);

    // 3: framing error followed by a held-low line
    idle(2);
    base_v  = vhi1;
    base_fe = fe1;
    send_frame(1'b0, 8'h81, 1'b0, 1);
    check_val("t3_fe_pulse", frame_err1, 1);
    check_val("t3_valid", valid1, 0);
    rx1 = 1'b0;
    tick();
    check_val("t3_fe_width", frame_err1, 0);
    repeat (4) tick();
    idle(14);
    check_val("t3_fe_count", fe1 - base_fe, 1);
    check_val("t3_no_word", vhi1 - base_v, 0);

    // 4: overrun while the consumer stalls
    ready1  = 1'b0;
    base_ov = ov1;
    send_frame(1'b0, 8'h11, 1'b1, 1);
    check_val("t4_valid_a", valid1, 1);
    check_val("t4_data_a", data1, 8'h11);
    send_frame(1'b0, 8'h22, 1'b1, 1);
    check_val("t4_overrun", overrun1, 1);
    check_val("t4_data_held", data1, 8'h11);
    idle(1);
    check_val("t4_ov_width", overrun1, 0);
    check_val("t4_valid_held", valid1, 1);
    check_val("t4_data_xfer", data1, 8'h11);
    ready1 = 1'b1;
    tick();
    check_val("t4_valid_drop", valid1, 0);
    check_val("t4_ov_count", ov1 - base_ov, 1);

    // 5: 4 clks/bit, glitch rejected, then a full frame
    base_v  = vhi4;
    base_fe = fe4;
    rx4 = 1'b0;
    tick();
    idle(12);
    check_val("t5_glitch_valid", vhi4 - base_v, 0);
    check_val("t5_glitch_fe", fe4 - base_fe, 0);
    send_frame(1'b1, 8'h5A, 1'b1, 4);
    check_val("t5_valid", valid4, 1);
    check_val("t5_data", data4, 8'h5A);
    check_val("t5_fe", fe4 - base_fe, 0);
    ready4 = 1'b1;
    idle(1);
    check_val("t5_valid_drop", valid4, 0);

    // 6: reset in the middle of a frame, with a stale word pending
    ready1 = 1'b0;
    send_frame(1'b0, 8'h99, 1'b1, 1);
    check_val("t6_pending", valid1, 1);
    rx1 = 1'b0; tick();              // start
    rx1 = 1'b1; tick();              // data bit 1
    tick();                          // data bit 2
    tick();                          // data bit 3
    RESET = 1'b1;                    // 4th data bit
    tick();
    check_val("t6_rst_valid", valid1, 0);
    check_val("t6_rst_data", data1, 0);
    check_val("t6_rst_fe", frame_err1, 0);
    check_val("t6_rst_ov", overrun1, 0);
    RESET  = 1'b0;
    ready1 = 1'b1;
    base_v = vhi1;
    idle(12);
    check_val("t6_abandoned", vhi1 - base_v, 0);
    send_frame(1'b0, 8'hF0, 1'b1, 1);
    check_val("t6_valid", valid1, 1);
    check_val("t6_data", data1, 8'hF0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
